// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int BLOCK_WIDTH = 4;                  // log2(line bytes)
    localparam int LINE_BYTES  = 2 ** BLOCK_WIDTH;   // 16-byte ICache line
    localparam int LINE_BITS   = LINE_BYTES * 8;
    localparam int LINE_AW     = 32 - BLOCK_WIDTH;   // line address width

    localparam logic [1:0] IO_SEL = 2'b11;           // addr[17:16] of the I/O region

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_DREAD  = 2'd2,
        ST_DWRITE = 2'd3
    } state_e;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DATA   = 1'b1
    } req_e;

    // Byte count of an LSU access; the reserved code 11 behaves as a word.
    function automatic logic [4:0] size_bytes(input logic [1:0] sz);
        logic [4:0] n;
        case (sz)
            SZ_B:    n = 5'd1;
            SZ_H:    n = 5'd2;
            default: n = 5'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the controller, ICache, LSU, RAM port and UART status.
interface mem_ctrl_if
    import mem_ctrl_pkg::*;
();
    logic                 flushIn;
    logic                 icMissIn;
    logic [LINE_AW-1:0]   icAddrIn;
    logic                 icValidOut;
    logic [LINE_AW-1:0]   icAddrOut;
    logic [LINE_BITS-1:0] icDataOut;
    logic                 dReqIn;
    logic                 dWriteIn;
    logic [1:0]           dSizeIn;
    logic [31:0]          dAddrIn;
    logic [31:0]          dWdataIn;
    logic                 dDoneOut;
    logic [31:0]          dRdataOut;
    logic [7:0]           ramDataIn;
    logic [7:0]           ramDataOut;
    logic [31:0]          ramAddrOut;
    logic                 ramWriteOut;
    logic                 ioBufFullIn;

    // Environment side: clients, RAM model and UART status.
    modport master (
        output flushIn, icMissIn, icAddrIn, dReqIn, dWriteIn, dSizeIn, dAddrIn,
               dWdataIn, ramDataIn, ioBufFullIn,
        input  icValidOut, icAddrOut, icDataOut, dDoneOut, dRdataOut,
               ramDataOut, ramAddrOut, ramWriteOut
    );

    // Controller side.
    modport slave (
        input  flushIn, icMissIn, icAddrIn, dReqIn, dWriteIn, dSizeIn, dAddrIn,
               dWdataIn, ramDataIn, ioBufFullIn,
        output icValidOut, icAddrOut, icDataOut, dDoneOut, dRdataOut,
               ramDataOut, ramAddrOut, ramWriteOut
    );
endinterface

// File: rtl/mem_byte_asm.sv
// Collects returned RAM bytes into a line buffer indexed by byte position.
// line_o/word_o already include the byte being written this cycle so the
// owner can latch a complete result on the same edge as the last byte.
module mem_byte_asm (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         we_i,
    input  logic [3:0]   idx_i,
    input  logic [7:0]   byte_i,
    output logic [127:0] line_o,
    output logic [31:0]  word_o
);
    logic [127:0] line_q;
    logic [127:0] line_d;

    // Merge the incoming byte into its slot of the buffer.
    always_comb begin
        line_d = line_q;
        if (we_i) begin
            line_d[{idx_i, 3'b000} +: 8] = byte_i;
        end else begin
            line_d = line_q;
        end
    end

    // Buffer register; cleared at each grant so unused upper bytes read as zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_q <= 128'd0;
        end else if (clr_i) begin
            line_q <= 128'd0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_d;
    assign word_o = line_d[31:0];
endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between ICache refills and LSU accesses,
// serialising each request into byte cycles.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input logic       clkIn,
    input logic       resetIn,
    mem_ctrl_if.slave bus
);
    state_e               state_q, state_d;
    req_e                 rr_q, rr_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [4:0]           nbytes_q, nbytes_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 ic_valid_q, ic_valid_d;
    logic [LINE_AW-1:0]   ic_addr_q, ic_addr_d;
    logic [LINE_BITS-1:0] ic_data_q, ic_data_d;
    logic                 d_done_q, d_done_d;
    logic [31:0]          d_rdata_q, d_rdata_d;

    logic                 pend_ic_s, pend_d_s, stall_s;
    logic                 asm_clr_s, asm_we_s;
    logic [3:0]           asm_idx_s;
    logic [LINE_BITS-1:0] asm_line_s;
    logic [31:0]          asm_word_s;
    logic [31:0]          ram_addr_s;
    logic [7:0]           ram_data_s, wr_byte_s;
    logic                 ram_write_s;

    assign pend_ic_s = bus.icMissIn & ~bus.flushIn;
    assign pend_d_s  = bus.dReqIn;
    assign stall_s   = bus.ioBufFullIn & (addr_q[17:16] == IO_SEL);
    // Byte returned this cycle belongs to the address issued one cycle earlier.
    assign asm_idx_s = cnt_q[3:0] - 4'd1;

    mem_byte_asm u_asm (
        .clk_i   (clkIn),
        .rst_n_i (resetIn),
        .clr_i   (asm_clr_s),
        .we_i    (asm_we_s),
        .idx_i   (asm_idx_s),
        .byte_i  (bus.ramDataIn),
        .line_o  (asm_line_s),
        .word_o  (asm_word_s)
    );

    // Next-state logic: arbitration, byte counting and result capture.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_valid_d = 1'b0;
        ic_addr_d  = ic_addr_q;
        ic_data_d  = ic_data_q;
        d_done_d   = 1'b0;
        d_rdata_d  = d_rdata_q;
        asm_clr_s  = 1'b0;
        asm_we_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Hold off while a completion pulse is out so a still-held request is not re-granted.
                if (!ic_valid_q && !d_done_q && (pend_ic_s || pend_d_s)) begin
                    if (pend_d_s && (!pend_ic_s || rr_q == REQ_ICACHE)) begin
                        rr_d     = REQ_DATA;
                        addr_d   = bus.dAddrIn;
                        nbytes_d = size_bytes(bus.dSizeIn);
                        wdata_d  = bus.dWdataIn;
                        state_d  = bus.dWriteIn ? ST_DWRITE : ST_DREAD;
                    end else begin
                        rr_d     = REQ_ICACHE;
                        addr_d   = {bus.icAddrIn, {BLOCK_WIDTH{1'b0}}};
                        nbytes_d = 5'(LINE_BYTES);
                        state_d  = ST_IFETCH;
                    end
                    cnt_d     = 5'd0;
                    asm_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IFETCH: begin
                if (bus.flushIn) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    asm_we_s = (cnt_q != 5'd0);
                    if (cnt_q == nbytes_q) begin
                        state_d    = ST_IDLE;
                        cnt_d      = 5'd0;
                        ic_valid_d = 1'b1;
                        ic_data_d  = asm_line_s;
                        ic_addr_d  = addr_q[31:BLOCK_WIDTH];
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_DREAD: begin
                asm_we_s = (cnt_q != 5'd0);
                if (cnt_q == nbytes_q) begin
                    state_d   = ST_IDLE;
                    cnt_d     = 5'd0;
                    d_done_d  = 1'b1;
                    d_rdata_d = asm_word_s;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DWRITE: begin
                if (stall_s) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == nbytes_q - 5'd1) begin
                    state_d  = ST_IDLE;
                    cnt_d    = 5'd0;
                    d_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Select the store byte for the current count.
    always_comb begin
        case (cnt_q[1:0])
            2'd0:    wr_byte_s = wdata_q[7:0];
            2'd1:    wr_byte_s = wdata_q[15:8];
            2'd2:    wr_byte_s = wdata_q[23:16];
            default: wr_byte_s = wdata_q[31:24];
        endcase
    end

    // RAM port decode; the UART-full stall must gate the write in the same cycle.
    always_comb begin
        ram_addr_s  = 32'd0;
        ram_data_s  = 8'd0;
        ram_write_s = 1'b0;
        case (state_q)
            ST_IFETCH, ST_DREAD: begin
                if (cnt_q < nbytes_q) begin
                    ram_addr_s = addr_q + {27'd0, cnt_q};
                end else begin
                    ram_addr_s = 32'd0;
                end
            end
            ST_DWRITE: begin
                ram_addr_s  = addr_q + {27'd0, cnt_q};
                ram_data_s  = wr_byte_s;
                ram_write_s = ~stall_s;
            end
            default: begin
                ram_addr_s = 32'd0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q    <= ST_IDLE;
            rr_q       <= REQ_ICACHE;
            cnt_q      <= 5'd0;
            nbytes_q   <= 5'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            ic_valid_q <= 1'b0;
            ic_addr_q  <= '0;
            ic_data_q  <= '0;
            d_done_q   <= 1'b0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_valid_q <= ic_valid_d;
            ic_addr_q  <= ic_addr_d;
            ic_data_q  <= ic_data_d;
            d_done_q   <= d_done_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.icValidOut  = ic_valid_q;
    assign bus.icAddrOut   = ic_addr_q;
    assign bus.icDataOut   = ic_data_q;
    assign bus.dDoneOut    = d_done_q;
    assign bus.dRdataOut   = d_rdata_q;
    assign bus.ramAddrOut  = ram_addr_s;
    assign bus.ramDataOut  = ram_data_s;
    assign bus.ramWriteOut = ram_write_s;
endmodule
